// File: rtl/regfile_arbiter.sv
// regfile_arbiter
// ---------------------------------------------------------------------------
// Two-master round-robin arbiter and sequencer for the shared register file
// command port. One transaction runs at a time: IDLE picks a winner, CMD
// pulses the write or read enable for one cycle, RWAIT waits (bounded by
// TIMEOUT) for the read-valid return, and RESP pulses the winner's Ack
// together with RdVld or Err. Every output is a flop.
//
// Ports
//   CLK, RST                   clock (rising edge), synchronous active-high reset
//   ReqN/WrN/AddrN/WrDataN     request from master N; held stable until AckN
//   AckN                       one-cycle completion pulse to master N
//   RdVldN                     one-cycle pulse with AckN on a successful read
//   RdDataN                    last read result for master N (held)
//   ErrN                       one-cycle pulse with AckN on a read timeout
//   RF_WrEn/RF_RdEn            register file command enables (one-cycle pulses)
//   RF_Address/RF_WrData       register file address and write data (held)
//   RF_RdData/RF_RdData_VLD    register file read return
//   Busy                       high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 2,
  parameter int TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req0,
  input  logic             Req1,
  input  logic             Wr0,
  input  logic             Wr1,
  input  logic [ADDR-1:0]  Addr0,
  input  logic [ADDR-1:0]  Addr1,
  input  logic [WIDTH-1:0] WrData0,
  input  logic [WIDTH-1:0] WrData1,
  output logic             Ack0,
  output logic             Ack1,
  output logic             RdVld0,
  output logic             RdVld1,
  output logic [WIDTH-1:0] RdData0,
  output logic [WIDTH-1:0] RdData1,
  output logic             Err0,
  output logic             Err1,
  output logic             RF_WrEn,
  output logic             RF_RdEn,
  output logic [ADDR-1:0]  RF_Address,
  output logic [WIDTH-1:0] RF_WrData,
  input  logic [WIDTH-1:0] RF_RdData,
  input  logic             RF_RdData_VLD,
  output logic             Busy
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The last RWAIT cycle is the one where the counter still reads TIMEOUT-1,
  // which puts the error Ack exactly TIMEOUT cycles after RWAIT is entered.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CMD, RWAIT, RESP} state_t;

  state_t           state;
  logic             sel;
  logic             sel_wr;
  logic             prio;
  logic [CNT_W-1:0] tmo_cnt;

  logic             grant_sel;
  logic             grant_wr;
  logic [ADDR-1:0]  grant_addr;
  logic [WIDTH-1:0] grant_wdata;

  // Winner selection: a lone requester wins outright, a tie goes to prio.
  always_comb begin
    grant_sel   = (Req0 && Req1) ? prio : Req1;
    grant_wr    = grant_sel ? Wr1 : Wr0;
    grant_addr  = grant_sel ? Addr1 : Addr0;
    grant_wdata = grant_sel ? WrData1 : WrData0;
  end

  // Sequencer. The command enables are loaded on the grant edge so they are
  // high during CMD; the per-master pulses are loaded on the edge into RESP
  // so they are high during RESP. All pulses default back to 0 every cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      sel        <= 1'b0;
      sel_wr     <= 1'b0;
      prio       <= 1'b0;
      tmo_cnt    <= '0;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      RdVld0     <= 1'b0;
      RdVld1     <= 1'b0;
      RdData0    <= '0;
      RdData1    <= '0;
      Err0       <= 1'b0;
      Err1       <= 1'b0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      Busy       <= 1'b0;
    end else begin
      RF_WrEn <= 1'b0;
      RF_RdEn <= 1'b0;
      Ack0    <= 1'b0;
      Ack1    <= 1'b0;
      RdVld0  <= 1'b0;
      RdVld1  <= 1'b0;
      Err0    <= 1'b0;
      Err1    <= 1'b0;

      case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            sel        <= grant_sel;
            sel_wr     <= grant_wr;
            prio       <= ~grant_sel;
            RF_Address <= grant_addr;
            // Reads leave the write-data bus untouched.
            if (grant_wr) begin
              RF_WrData <= grant_wdata;
            end
            RF_WrEn    <= grant_wr;
            RF_RdEn    <= ~grant_wr;
            Busy       <= 1'b1;
            state      <= CMD;
          end
        end

        CMD: begin
          tmo_cnt <= '0;
          if (sel_wr) begin
            Ack0  <= ~sel;
            Ack1  <= sel;
            state <= RESP;
          end else begin
            state <= RWAIT;
          end
        end

        RWAIT: begin
          if (RF_RdData_VLD) begin
            if (sel) begin
              RdData1 <= RF_RdData;
            end else begin
              RdData0 <= RF_RdData;
            end
            Ack0   <= ~sel;
            Ack1   <= sel;
            RdVld0 <= ~sel;
            RdVld1 <= sel;
            state  <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (tmo_cnt == CNT_LAST) begin
              Ack0  <= ~sel;
              Ack1  <= sel;
              Err0  <= ~sel;
              Err1  <= sel;
              state <= RESP;
            end
          end
        end

        RESP: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter
// ---------------------------------------------------------------------------
// Cycle-by-cycle directed vectors for regfile_arbiter. Each vector holds the
// inputs driven for one clock cycle and the outputs required just after the
// following rising edge. A small register file model answers reads one cycle
// after RF_RdEn unless its respond flag is cleared (used for the timeout).
// A hand-written sequence at the end measures write latency with a bounded
// wait and checks the model memory was actually written.
// ---------------------------------------------------------------------------
module tb_regfile_arbiter;

  logic       CLK;
  logic       RST;
  logic       Req0, Req1, Wr0, Wr1;
  logic [1:0] Addr0, Addr1;
  logic [7:0] WrData0, WrData1;
  logic       Ack0, Ack1, RdVld0, RdVld1, Err0, Err1;
  logic [7:0] RdData0, RdData1;
  logic       RF_WrEn, RF_RdEn;
  logic [1:0] RF_Address;
  logic [7:0] RF_WrData;
  logic [7:0] RF_RdData;
  logic       RF_RdData_VLD;
  logic       Busy;

  logic       rf_respond;
  logic [7:0] rf_mem [4];

  int n_vec;
  int n_fail;

  typedef struct packed {
    logic       rst;
    logic       req0;
    logic       wr0;
    logic [1:0] addr0;
    logic [7:0] wdata0;
    logic       req1;
    logic       wr1;
    logic [1:0] addr1;
    logic [7:0] wdata1;
    logic       rsp;
  } stim_t;

  typedef struct packed {
    logic       ack0;
    logic       ack1;
    logic       rv0;
    logic       rv1;
    logic       err0;
    logic       err1;
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       wen;
    logic       ren;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       busy;
  } resp_t;

  typedef struct packed {
    stim_t s;
    resp_t e;
  } vec_t;

  vec_t vq[$];

  regfile_arbiter #(.WIDTH(8), .ADDR(2), .TIMEOUT(4)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Req0          (Req0),
    .Req1          (Req1),
    .Wr0           (Wr0),
    .Wr1           (Wr1),
    .Addr0         (Addr0),
    .Addr1         (Addr1),
    .WrData0       (WrData0),
    .WrData1       (WrData1),
    .Ack0          (Ack0),
    .Ack1          (Ack1),
    .RdVld0        (RdVld0),
    .RdVld1        (RdVld1),
    .RdData0       (RdData0),
    .RdData1       (RdData1),
    .Err0          (Err0),
    .Err1          (Err1),
    .RF_WrEn       (RF_WrEn),
    .RF_RdEn       (RF_RdEn),
    .RF_Address    (RF_Address),
    .RF_WrData     (RF_WrData),
    .RF_RdData     (RF_RdData),
    .RF_RdData_VLD (RF_RdData_VLD),
    .Busy          (Busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Register file model: one-cycle read latency, writes land on the edge.
  initial begin
    for (int i = 0; i < 4; i++) rf_mem[i] = 8'h00;
    RF_RdData     = 8'h00;
    RF_RdData_VLD = 1'b0;
  end

  always @(posedge CLK) begin
    RF_RdData_VLD <= RF_RdEn && rf_respond;
    if (RF_RdEn) RF_RdData <= rf_mem[RF_Address];
    if (RF_WrEn) rf_mem[RF_Address] <= RF_WrData;
  end

  function automatic stim_t st(input logic rst, input logic r0, input logic w0,
                               input logic [1:0] a0, input logic [7:0] d0,
                               input logic r1, input logic w1,
                               input logic [1:0] a1, input logic [7:0] d1,
                               input logic rsp);
    stim_t s;
    s = '{rst, r0, w0, a0, d0, r1, w1, a1, d1, rsp};
    return s;
  endfunction

  function automatic resp_t ex(input logic ack0, input logic ack1,
                               input logic rv0, input logic rv1,
                               input logic err0, input logic err1,
                               input logic [7:0] rd0, input logic [7:0] rd1,
                               input logic wen, input logic ren,
                               input logic [1:0] addr, input logic [7:0] wdata,
                               input logic busy);
    resp_t r;
    r = '{ack0, ack1, rv0, rv1, err0, err1, rd0, rd1, wen, ren, addr, wdata, busy};
    return r;
  endfunction

  task automatic addVec(input stim_t s, input resp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vq.push_back(v);
  endtask

  // Drive one cycle's inputs on the falling edge.
  task automatic applyStimulus(input stim_t s);
    @(negedge CLK);
    RST        = s.rst;
    Req0       = s.req0;
    Wr0        = s.wr0;
    Addr0      = s.addr0;
    WrData0    = s.wdata0;
    Req1       = s.req1;
    Wr1        = s.wr1;
    Addr1      = s.addr1;
    WrData1    = s.wdata1;
    rf_respond = s.rsp;
  endtask

  // Wait for the rising edge, then compare every output just after it.
  task automatic checkOutput(input string name, input resp_t e);
    resp_t a;
    @(posedge CLK);
    #1;
    a = '{Ack0, Ack1, RdVld0, RdVld1, Err0, Err1, RdData0, RdData1,
          RF_WrEn, RF_RdEn, RF_Address, RF_WrData, Busy};
    n_vec++;
    if (a !== e) begin
      n_fail++;
      $display("[TB] FAIL %s: got ack=%b%b rv=%b%b err=%b%b rd0=%h rd1=%h wen=%b ren=%b addr=%0d wdata=%h busy=%b | required ack=%b%b rv=%b%b err=%b%b rd0=%h rd1=%h wen=%b ren=%b addr=%0d wdata=%h busy=%b",
               name, a.ack0, a.ack1, a.rv0, a.rv1, a.err0, a.err1, a.rd0, a.rd1,
               a.wen, a.ren, a.addr, a.wdata, a.busy,
               e.ack0, e.ack1, e.rv0, e.rv1, e.err0, e.err1, e.rd0, e.rd1,
               e.wen, e.ren, e.addr, e.wdata, e.busy);
    end
  endtask

  task automatic checkValue(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  initial begin
    stim_t idle;
    int    lat;
    logic  seen;

    n_vec  = 0;
    n_fail = 0;
    RST = 1'b1; Req0 = 1'b0; Req1 = 1'b0; Wr0 = 1'b0; Wr1 = 1'b0;
    Addr0 = 2'd0; Addr1 = 2'd0; WrData0 = 8'h00; WrData1 = 8'h00;
    rf_respond = 1'b1;
    idle = st(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00, 1);

    // Reset, then master 0 writes 0x5A to register 2.
    addVec(st(1, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd0,8'h00, 0));
    addVec(idle,                                     ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd0,8'h00, 0));
    addVec(st(0, 1,1,2'd2,8'h5A, 0,0,2'd0,8'h00, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 1,0,2'd2,8'h5A, 1));
    addVec(st(0, 1,1,2'd2,8'h5A, 0,0,2'd0,8'h00, 1), ex(1,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd2,8'h5A, 1));
    addVec(idle,                                     ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd2,8'h5A, 0));
    // Master 1 reads register 2 back; write data bus stays at 0x5A.
    addVec(st(0, 0,0,2'd0,8'h00, 1,0,2'd2,8'h33, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,1,2'd2,8'h5A, 1));
    addVec(st(0, 0,0,2'd0,8'h00, 1,0,2'd2,8'h33, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd2,8'h5A, 1));
    addVec(st(0, 0,0,2'd0,8'h00, 1,0,2'd2,8'h33, 1), ex(0,1,0,1,0,0, 8'h00,8'h5A, 0,0,2'd2,8'h5A, 1));
    addVec(idle,                                     ex(0,0,0,0,0,0, 8'h00,8'h5A, 0,0,2'd2,8'h5A, 0));
    // Reset with both requesting, then both held: grants go 0,1,0,1.
    addVec(st(1, 1,1,2'd1,8'h11, 1,1,2'd3,8'h22, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd0,8'h00, 0));
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 0) begin
        addVec(st(0, 1,1,2'd1,8'h11, 1,1,2'd3,8'h22, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 1,0,2'd1,8'h11, 1));
        addVec(st(0, 1,1,2'd1,8'h11, 1,1,2'd3,8'h22, 1), ex(1,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd1,8'h11, 1));
        addVec(st(0, 1,1,2'd1,8'h11, 1,1,2'd3,8'h22, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd1,8'h11, 0));
      end else begin
        addVec(st(0, 1,1,2'd1,8'h11, 1,1,2'd3,8'h22, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 1,0,2'd3,8'h22, 1));
        addVec(st(0, 1,1,2'd1,8'h11, 1,1,2'd3,8'h22, 1), ex(0,1,0,0,0,0, 8'h00,8'h00, 0,0,2'd3,8'h22, 1));
        if (g == 3)
          addVec(idle,                               ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd3,8'h22, 0));
        else
          addVec(st(0, 1,1,2'd1,8'h11, 1,1,2'd3,8'h22, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd3,8'h22, 0));
      end
    end
    // Master 0 reads register 1 (0x11) successfully.
    addVec(st(0, 1,0,2'd1,8'h00, 0,0,2'd0,8'h00, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,1,2'd1,8'h22, 1));
    addVec(st(0, 1,0,2'd1,8'h00, 0,0,2'd0,8'h00, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd1,8'h22, 1));
    addVec(st(0, 1,0,2'd1,8'h00, 0,0,2'd0,8'h00, 1), ex(1,0,1,0,0,0, 8'h11,8'h00, 0,0,2'd1,8'h22, 1));
    addVec(idle,                                     ex(0,0,0,0,0,0, 8'h11,8'h00, 0,0,2'd1,8'h22, 0));
    // Master 0 read of register 3 never answered: Err at N+6, Busy low at N+7.
    addVec(st(0, 1,0,2'd3,8'h00, 0,0,2'd0,8'h00, 0), ex(0,0,0,0,0,0, 8'h11,8'h00, 0,1,2'd3,8'h22, 1));
    for (int w = 0; w < 4; w++)
      addVec(st(0, 1,0,2'd3,8'h00, 0,0,2'd0,8'h00, 0), ex(0,0,0,0,0,0, 8'h11,8'h00, 0,0,2'd3,8'h22, 1));
    addVec(st(0, 1,0,2'd3,8'h00, 0,0,2'd0,8'h00, 0), ex(1,0,0,0,1,0, 8'h11,8'h00, 0,0,2'd3,8'h22, 1));
    addVec(st(0, 0,0,2'd0,8'h00, 0,0,2'd0,8'h00, 0), ex(0,0,0,0,0,0, 8'h11,8'h00, 0,0,2'd3,8'h22, 0));
    // Reset while in RWAIT (read data about to arrive): no Ack, all outputs 0.
    addVec(st(0, 1,0,2'd2,8'h00, 0,0,2'd0,8'h00, 1), ex(0,0,0,0,0,0, 8'h11,8'h00, 0,1,2'd2,8'h22, 1));
    addVec(st(0, 1,0,2'd2,8'h00, 0,0,2'd0,8'h00, 1), ex(0,0,0,0,0,0, 8'h11,8'h00, 0,0,2'd2,8'h22, 1));
    addVec(st(1, 1,0,2'd2,8'h00, 0,0,2'd0,8'h00, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd0,8'h00, 0));
    // Tie right after reset goes to master 0; master 1's read waits, then completes.
    addVec(st(0, 1,1,2'd0,8'h44, 1,0,2'd3,8'h00, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 1,0,2'd0,8'h44, 1));
    addVec(st(0, 1,1,2'd0,8'h44, 1,0,2'd3,8'h00, 1), ex(1,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd0,8'h44, 1));
    addVec(st(0, 0,0,2'd0,8'h00, 1,0,2'd3,8'h00, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd0,8'h44, 0));
    addVec(st(0, 0,0,2'd0,8'h00, 1,0,2'd3,8'h00, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,1,2'd3,8'h44, 1));
    addVec(st(0, 0,0,2'd0,8'h00, 1,0,2'd3,8'h00, 1), ex(0,0,0,0,0,0, 8'h00,8'h00, 0,0,2'd3,8'h44, 1));
    addVec(st(0, 0,0,2'd0,8'h00, 1,0,2'd3,8'h00, 1), ex(0,1,0,1,0,0, 8'h00,8'h22, 0,0,2'd3,8'h44, 1));
    addVec(idle,                                     ex(0,0,0,0,0,0, 8'h00,8'h22, 0,0,2'd3,8'h44, 0));

    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i].s);
      checkOutput($sformatf("vec%0d", i), vq[i].e);
    end

    // Master 1 write of 0x77 to register 1: Ack1 must appear two edges later.
    applyStimulus(st(0, 0,0,2'd0,8'h00, 1,1,2'd1,8'h77, 1));
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (!seen) begin
        @(posedge CLK);
        #1;
        if (Ack1) begin
          seen = 1'b1;
          lat  = c;
        end
      end
    end
    checkValue("write_ack_latency", 8'(lat), 8'd2);
    checkValue("write_ack_flags", {4'b0, Ack0, RdVld1, Err1, Err0}, 8'h00);
    checkValue("write_rd1_hold", RdData1, 8'h22);
    applyStimulus(idle);
    @(posedge CLK);
    #1;
    checkValue("write_busy_drop", {7'b0, Busy}, 8'h00);
    checkValue("rf_mem1_written", rf_mem[1], 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4×8 register file port. It serialises read and write transactions from two independent masters onto the register file's single command interface (write enable, read enable, address and write data) and waits for the read-valid return. It then delivers a registered acknowledge, plus read data where applicable, to the winning master. It sits between the pipeline stages that access architectural registers and the register file.

## Interface
- WIDTH, 8, data width; matches register file word width
- ADDR, 2, address width; matches register file depth of 4
- TIMEOUT, 4, max cycles spent in RWAIT waiting for RF_RdData_VLD before error completion (≥1)

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- Req0 / Req1  in  1  transaction request, held until Ack
- Wr0 / Wr1  in  1  1 = write, 0 = read; stable while Req high
- Addr0 / Addr1  in  ADDR  target register; stable while Req high
- WrData0 / WrData1  in  WIDTH  write data; stable while Req high
- Ack0 / Ack1  out  1  one-cycle completion pulse
- RdVld0 / RdVld1  out  1  one-cycle pulse with Ack on successful read
- RdData0 / RdData1  out  WIDTH  read result, valid when RdVld high, holds until next read for that master
- Err0 / Err1  out  1  one-cycle pulse with Ack on read timeout
- RF_WrEn  out  1  register file write enable (one-cycle pulse)
- RF_RdEn  out  1  register file read enable (one-cycle pulse)
- RF_Address  out  ADDR  register file address
- RF_WrData  out  WIDTH  register file write data
- RF_RdData  in  WIDTH  register file read data
- RF_RdData_VLD  in  1  register file read-data valid
- Busy  out  1  high whenever state ≠ IDLE

## Operation
- All outputs are registered. Reset value of every output is 0.
- On reset: state = IDLE, Prio = 0, Sel = 0, timeout counter = 0.
- Prio: the master with priority on a tie. After any grant to master n, Prio ← 1−n.
- FSM states: IDLE, CMD, RWAIT, RESP.
- IDLE:
  - No Req: stay in IDLE.
  - Exactly one Req: grant that master.
  - Both Req: grant master Prio.
  - On grant: Sel ← winner; RF_Address ← Addr_Sel; RF_WrData ← WrData_Sel (write only); state → CMD.
- CMD (exactly one cycle):
  - RF_WrEn = Wr_Sel, RF_RdEn = ~Wr_Sel; never both high.
  - Write: → RESP.
  - Read: → RWAIT, counter cleared.
- RWAIT:
  - RF_RdData_VLD high: capture RF_RdData into RdData_Sel; → RESP with success flag.
  - Otherwise: counter increments. When counter reaches TIMEOUT, → RESP with error flag; RdData_Sel is unchanged.
- RESP (one cycle):
  - Ack_Sel = 1.
  - Read success: RdVld_Sel = 1.
  - Timeout: Err_Sel = 1.
  - Write: RdVld and Err stay 0.
  - → IDLE.
- Non-selected master outputs are 0 at all times.
- RF_Address and RF_WrData hold their last value between commands. RF_WrData is not updated on reads.
- Requests are sampled only in IDLE. Requests that arrive mid-transaction wait.
- Reset mid-transaction: the transaction is abandoned; no Ack/RdVld/Err is issued; all outputs → 0 in the cycle after RST is sampled high.
- A master must drop Req or present a new command the cycle after Ack. If Req is still high in IDLE, it is treated as a new request.

## Timing
- Write: request sampled in IDLE at cycle N → RF_WrEn in N+1 → Ack in N+2 → IDLE in N+3.
- Read with a 1-cycle register file: IDLE at N → RF_RdEn in N+1 → RF_RdData_VLD seen in N+2 → Ack + RdVld + RdData in N+3 → IDLE in N+4.
- Read timeout: Ack + Err at N+2+TIMEOUT.
- Throughput: 1 write per 3 cycles, 1 read per 4 cycles.
- Starvation bound: with both masters continuously requesting, grants alternate strictly.

## Test plan
- Reset then single write: Req0=1, Wr0=1, Addr0=2, WrData0=0x5A → RF_WrEn pulse with RF_Address=2, RF_WrData=0x5A at N+1; Ack0 at N+2; Ack1/RdVld0/Err0 stay 0.
- Read back via master 1: Req1=1, Wr1=0, Addr1=2, with a register file model returning 0x5A one cycle after RdEn → Ack1, RdVld1, RdData1=0x5A at N+3; RdData0 unchanged.
- Simultaneous requests from reset: Req0 = Req1 = 1, held continuously → grant order 0, 1, 0, 1; each Ack exactly once per transaction; RF_WrEn and RF_RdEn never high together.
- Read timeout: hold RF_RdData_VLD=0, TIMEOUT=4 → Ack0 + Err0 at N+6, RdVld0=0, RdData0 keeps its previous value; Busy falls at N+7.
- Reset mid-read: assert RST in RWAIT → next cycle all outputs 0, state IDLE, Prio=0, no Ack issued; a fresh Req1 afterwards completes normally.
